// File: rtl/ex_wb_stage.sv
// Writeback stage behind the ALU: 2-entry skid buffer for result/rd/wen,
// plus the architectural Z/N flag register and branch resolution at accept.
module ex_wb_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned RA_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_zero,
    input  logic             in_neg,
    input  logic [RA_W-1:0]  in_rd,
    input  logic             in_wen,
    input  logic             in_setf,
    input  logic [1:0]       in_br,
    input  logic [WIDTH-1:0] in_br_target,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RA_W-1:0]  out_rd,
    output logic             out_wen,
    output logic             flag_z,
    output logic             flag_n,
    output logic             br_taken,
    output logic [WIDTH-1:0] br_target
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [RA_W-1:0]  rd;
        logic             wen;
    } beat_t;

    beat_t main_q;
    beat_t skid_q;
    beat_t in_beat;
    logic  main_valid;
    logic  skid_free;
    logic  accept;
    logic  xfer;
    logic  taken;

    assign in_beat = {in_result, in_rd, in_wen};

    // Flush overrides any offered beat, so it blocks accept-side effects too.
    always_comb begin
        accept = in_valid && skid_free && !flush;
        xfer   = main_valid && out_ready;
        taken  = 1'b0;
        case (in_br)
            2'b01:   taken = in_zero;
            2'b10:   taken = in_neg;
            2'b11:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // Skid buffer: main drives the outputs, skid only fills when main stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_free  <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_free  <= 1'b1;
        end else if (!skid_free) begin
            if (xfer) begin
                main_q    <= skid_q;
                skid_free <= 1'b1;
            end
        end else if (accept) begin
            if (!main_valid || xfer) begin
                main_q     <= in_beat;
                main_valid <= 1'b1;
            end else begin
                skid_q    <= in_beat;
                skid_free <= 1'b0;
            end
        end else if (xfer) begin
            main_valid <= 1'b0;
        end
    end

    // Flags and redirect resolve at accept time, independent of writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            br_taken  <= 1'b0;
            br_target <= '0;
        end else begin
            br_taken <= accept && taken;
            if (accept && taken) begin
                br_target <= in_br_target;
            end
            if (accept && in_setf) begin
                flag_z <= in_zero;
                flag_n <= in_neg;
            end
        end
    end

    assign in_ready   = skid_free;
    assign out_valid  = main_valid;
    assign out_result = main_q.result;
    assign out_rd     = main_q.rd;
    assign out_wen    = main_q.wen;

endmodule
